// File: rtl/uart_rx_frame_timer.sv
// Oversampling bit/frame timer for a UART receiver: start, data, optional parity, 1-2 stop bits.
// Optional macro UART_RX_TIMER_OVERSAMPLE3_EN widens sample_stb to three cycles and adds sample_last.
module uart_rx_frame_timer #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int PRESCALE_W     = 6,
  parameter int BIT_CNT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [1:0]            phase,
  output logic                  sample_stb,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
`ifdef UART_RX_TIMER_OVERSAMPLE3_EN
  ,
  output logic                  sample_last
`endif
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_WIDTH);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [3:0]            len_q, len_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [PRESCALE_W-1:0] p_m1, mid;
  logic [BIT_CNT_W-1:0]  last_bit, len_ext;
  logic                  active;

  assign p_m1     = p_q - PRESCALE_W'(1);
  assign mid      = p_q >> 1;
  assign len_ext  = BIT_CNT_W'(len_q);
  assign last_bit = len_ext + BIT_CNT_W'(par_q) + BIT_CNT_W'(stop2_q) + BIT_CNT_W'(1);
  assign active   = enable & (state_q == RUN) & ~cfg_err_q;

  assign bit_done   = active & (edge_cnt_q == p_m1);
  assign frame_done = bit_done & (bit_cnt_q == last_bit);

`ifdef UART_RX_TIMER_OVERSAMPLE3_EN
  // Three-sample window around mid-bit for majority voting.
  assign sample_stb  = active & ((edge_cnt_q == mid - PRESCALE_W'(1)) |
                                 (edge_cnt_q == mid) |
                                 (edge_cnt_q == mid + PRESCALE_W'(1)));
  assign sample_last = active & (edge_cnt_q == mid + PRESCALE_W'(1));
`else
  assign sample_stb  = active & (edge_cnt_q == mid);
`endif

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  assign cfg_err  = cfg_err_q;

  always_comb begin
    phase = 2'd3;
    if (bit_cnt_q == '0)
      phase = 2'd0;
    else if (bit_cnt_q <= len_ext)
      phase = 2'd1;
    else if (par_q && (bit_cnt_q == len_ext + BIT_CNT_W'(1)))
      phase = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    p_d        = p_q;
    len_d      = len_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    cfg_err_d  = cfg_err_q;
    if (!enable) begin
      // Idle: track the configuration inputs so the next frame uses fresh settings.
      p_d        = prescale;
      len_d      = data_len;
      par_d      = par_en;
      stop2_d    = stop2;
      cfg_err_d  = (prescale < PRESCALE_W'(4)) | (data_len < 4'd5) | (data_len > MAX_LEN);
      state_d    = RUN;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (cfg_err_q || (state_q == HOLD)) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_done) begin
      edge_cnt_d = '0;
      if (frame_done) begin
        bit_cnt_d = '0;
        state_d   = HOLD;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= RUN;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      p_q        <= PRESCALE_W'(8);
      len_q      <= 4'd8;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      p_q        <= p_d;
      len_q      <= len_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Self-checking bench for uart_rx_frame_timer against an arithmetic frame model.
// Honours UART_RX_TIMER_OVERSAMPLE3_EN when defined.
module tb_uart_rx_frame_timer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [5:0] prescale;
  logic [3:0] data_len;
  logic       par_en;
  logic       stop2;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] phase;
  logic       sample_stb;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;
`ifdef UART_RX_TIMER_OVERSAMPLE3_EN
  logic       sample_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_timer #(.MAX_DATA_WIDTH(8), .PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .prescale   (prescale),
    .data_len   (data_len),
    .par_en     (par_en),
    .stop2      (stop2),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .phase      (phase),
    .sample_stb (sample_stb),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
`ifdef UART_RX_TIMER_OVERSAMPLE3_EN
    ,
    .sample_last(sample_last)
`endif
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected outputs after k enabled clock edges of a frame with the given latched config.
  task automatic checkModel(input int k, input int p, input int len, input int par, input int st);
    int err, total, ncyc, e, b, ph, ss, sl, bd, fd, mid;
    err   = (p < 4 || len < 5 || len > 8) ? 1 : 0;
    total = 1 + len + par + 1 + st;
    ncyc  = p * total;
    mid   = p / 2;
    e = 0; b = 0; ss = 0; sl = 0; bd = 0; fd = 0;
    if (!err && k < ncyc) begin
      e  = k % p;
      b  = k / p;
      bd = (e == p - 1) ? 1 : 0;
      fd = (k == ncyc - 1) ? 1 : 0;
`ifdef UART_RX_TIMER_OVERSAMPLE3_EN
      ss = (e >= mid - 1 && e <= mid + 1) ? 1 : 0;
      sl = (e == mid + 1) ? 1 : 0;
`else
      ss = (e == mid) ? 1 : 0;
`endif
    end
    if (b == 0) ph = 0;
    else if (b <= len) ph = 1;
    else if (par != 0 && b == len + 1) ph = 2;
    else ph = 3;
    checkOutput("edge_cnt", edge_cnt, e);
    checkOutput("bit_cnt", bit_cnt, b);
    checkOutput("phase", phase, ph);
    checkOutput("sample_stb", sample_stb, ss);
    checkOutput("bit_done", bit_done, bd);
    checkOutput("frame_done", frame_done, fd);
    checkOutput("cfg_err", cfg_err, err);
`ifdef UART_RX_TIMER_OVERSAMPLE3_EN
    checkOutput("sample_last", sample_last, sl);
`else
    if (sl != 0) checkOutput("sample_last_model", sl, 0);
`endif
  endtask

  // Drop enable for one cycle to load a config; returns just after the following negedge.
  task automatic applyStimulus(input int p, input int len, input int par, input int st);
    @(negedge CLK);
    enable   = 1'b0;
    prescale = 6'(p);
    data_len = 4'(len);
    par_en   = 1'(par);
    stop2    = 1'(st);
    #1;
    checkOutput("idle_sample_stb", sample_stb, 0);
    checkOutput("idle_bit_done", bit_done, 0);
    checkOutput("idle_frame_done", frame_done, 0);
    @(negedge CLK);
    #1;
    checkOutput("load_cfg_err", cfg_err, (p < 4 || len < 5 || len > 8) ? 1 : 0);
    checkOutput("load_edge_cnt", edge_cnt, 0);
    checkOutput("load_bit_cnt", bit_cnt, 0);
  endtask

  // Hold enable high for ncyc checks while scrambling the config inputs, which must be ignored.
  task automatic runEnabled(input int p, input int len, input int par, input int st, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(negedge CLK);
        #1;
      end
      enable   = 1'b1;
      prescale = 6'($urandom);
      data_len = 4'($urandom);
      par_en   = 1'($urandom);
      stop2    = 1'($urandom);
      #1;
      checkModel(k, p, len, par, st);
    end
  endtask

  initial begin
    int p, len, par, st;
    RST      = 1'b0;
    enable   = 1'b1;
    prescale = 6'd5;
    data_len = 4'd6;
    par_en   = 1'b1;
    stop2    = 1'b1;
    #3;
    checkOutput("rst_edge_cnt", edge_cnt, 0);
    checkOutput("rst_bit_cnt", bit_cnt, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    // Reset config (P=8, 8N1) is used without any load.
    runEnabled(8, 8, 0, 0, 85);

    applyStimulus(16, 7, 1, 1);
    runEnabled(16, 7, 1, 1, 180);
    applyStimulus(8, 8, 0, 0);
    runEnabled(8, 8, 0, 0, 84);
    applyStimulus(16, 8, 0, 0);
    runEnabled(16, 8, 0, 0, 164);
    applyStimulus(4, 5, 0, 0);
    runEnabled(4, 5, 0, 0, 30);

    applyStimulus(3, 8, 0, 0);
    runEnabled(3, 8, 0, 0, 20);
    applyStimulus(8, 9, 0, 0);
    runEnabled(8, 9, 0, 0, 20);
    applyStimulus(8, 4, 1, 1);
    runEnabled(8, 4, 1, 1, 20);
    applyStimulus(63, 8, 1, 1);
    runEnabled(63, 8, 1, 1, 12 * 63 + 3);

    for (int i = 0; i < 8; i++) begin
      p   = int'($urandom_range(20, 4));
      len = int'($urandom_range(8, 5));
      par = int'($urandom_range(1, 0));
      st  = int'($urandom_range(1, 0));
      applyStimulus(p, len, par, st);
      runEnabled(p, len, par, st, p * (2 + len + par + st) + 3);
    end

    // Abort at bit 5, edge 3 of a P=12 frame; reset must restore the default config.
    applyStimulus(12, 6, 1, 0);
    runEnabled(12, 6, 1, 0, 5 * 12 + 3 + 1);
    checkOutput("pre_rst_bit_cnt", bit_cnt, 5);
    checkOutput("pre_rst_edge_cnt", edge_cnt, 3);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("abort_edge_cnt", edge_cnt, 0);
    checkOutput("abort_bit_cnt", bit_cnt, 0);
    checkOutput("abort_frame_done", frame_done, 0);
    checkOutput("abort_bit_done", bit_done, 0);
    checkOutput("abort_sample_stb", sample_stb, 0);
    @(negedge CLK);
    #1;
    checkOutput("abort_hold_frame_done", frame_done, 0);
    checkOutput("abort_hold_edge_cnt", edge_cnt, 0);
    RST = 1'b1;
    runEnabled(8, 8, 0, 0, 83);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
